// File: rtl/umi_fifo_lfsr.sv
// rtl/umi_fifo_lfsr.sv - 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) for chaos back-pressure
module umi_fifo_lfsr (
    input  logic        clk,
    input  logic        nreset,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    // Taps at bits 16,14,13,11 map to indices 15,13,12,10; free-running regardless of chaosmode.
    always_comb begin
        feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d   = {lfsr_q[14:0], feedback};
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lfsr_q <= 16'h0001;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/umi_fifo_sync.sv
// rtl/umi_fifo_sync.sv - synchronous UMI FIFO with empty-only bypass and LFSR chaos back-pressure
module umi_fifo_sync #(
    parameter int DW        = 128,
    parameter int AW        = 64,
    parameter int CW        = 32,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   bypass,
    input  logic                   chaosmode,
    input  logic                   umi_in_valid,
    output logic                   umi_in_ready,
    input  logic [CW-1:0]          umi_in_cmd,
    input  logic [AW-1:0]          umi_in_dstaddr,
    input  logic [AW-1:0]          umi_in_srcaddr,
    input  logic [DW-1:0]          umi_in_data,
    output logic                   umi_out_valid,
    input  logic                   umi_out_ready,
    output logic [CW-1:0]          umi_out_cmd,
    output logic [AW-1:0]          umi_out_dstaddr,
    output logic [AW-1:0]          umi_out_srcaddr,
    output logic [DW-1:0]          umi_out_data,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic                   fifo_afull,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int AWID = $clog2(DEPTH);
    localparam int PW   = AWID + 1;
    localparam int EW   = CW + 2 * AW + DW;
    localparam logic [PW-1:0] AFULL_LVL_W = PW'(AFULL_LVL);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] in_entry;
    logic [EW-1:0] out_entry;
    logic [15:0]   lfsr;
    logic          unused_lfsr;
    logic          chaos_block;
    logic          bypass_active;
    logic          push;
    logic          pop;

    umi_fifo_lfsr u_lfsr (
        .clk    (clk),
        .nreset (nreset),
        .lfsr   (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:1];
    assign chaos_block = chaosmode & lfsr[0];

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AWID] != rptr_q[AWID]) &&
                        (wptr_q[AWID-1:0] == rptr_q[AWID-1:0]);
    assign fifo_level = wptr_q - rptr_q;
    assign fifo_afull = (fifo_level >= AFULL_LVL_W);

    // Bypass only engages once drained, so queued entries always leave first.
    assign bypass_active = bypass & fifo_empty;

    assign in_entry  = {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data};
    assign out_entry = bypass_active ? in_entry : mem[rptr_q[AWID-1:0]];
    assign {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} = out_entry;

    assign umi_in_ready  = bypass_active ? umi_out_ready : (~fifo_full & ~chaos_block);
    assign umi_out_valid = bypass_active ? umi_in_valid : ~fifo_empty;

    assign push = umi_in_valid & umi_in_ready & ~bypass_active;
    assign pop  = umi_out_ready & ~fifo_empty & ~bypass_active;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage carries no reset; a write during reset is orphaned because wptr stays at zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q[AWID-1:0]] <= in_entry;
        end
    end

endmodule

// File: tb/tb_umi_fifo_sync.sv
// tb/tb_umi_fifo_sync.sv - directed self-checking bench for umi_fifo_sync
module tb_umi_fifo_sync;

    localparam int DW = 128;
    localparam int AW = 64;
    localparam int CW = 32;

    logic          clk;
    logic          nreset;
    logic          bypass;
    logic          chaosmode;
    logic          umi_in_valid;
    logic          umi_in_ready;
    logic [CW-1:0] umi_in_cmd;
    logic [AW-1:0] umi_in_dstaddr;
    logic [AW-1:0] umi_in_srcaddr;
    logic [DW-1:0] umi_in_data;
    logic          umi_out_valid;
    logic          umi_out_ready;
    logic [CW-1:0] umi_out_cmd;
    logic [AW-1:0] umi_out_dstaddr;
    logic [AW-1:0] umi_out_srcaddr;
    logic [DW-1:0] umi_out_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_afull;
    logic [2:0]    fifo_level;

    int total;
    int bad;

    umi_fifo_sync #(.DW(DW), .AW(AW), .CW(CW), .DEPTH(4), .AFULL_LVL(3)) dut (
        .clk             (clk),
        .nreset          (nreset),
        .bypass          (bypass),
        .chaosmode       (chaosmode),
        .umi_in_valid    (umi_in_valid),
        .umi_in_ready    (umi_in_ready),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_out_valid   (umi_out_valid),
        .umi_out_ready   (umi_out_ready),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .fifo_afull      (fifo_afull),
        .fifo_level      (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic v, input int k);
        umi_in_valid   = v;
        umi_in_data    = DW'(k);
        umi_in_cmd     = CW'(k) ^ 32'hC0DE_0000;
        umi_in_dstaddr = AW'(k) + 64'h1000;
        umi_in_srcaddr = AW'(k) + 64'h2000;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0; bypass = 1'b0; chaosmode = 1'b0; umi_out_ready = 1'b0;
        set_in(1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", fifo_empty); end
        total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", fifo_full); end
        total++; if (fifo_afull !== 1'b0) begin bad++; $display("FAIL reset_afull got=%0b exp=0", fifo_afull); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        total++; if (umi_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", umi_out_valid); end
        next_cycle();
        nreset = 1'b1;
        #2;
    endtask

    task automatic test_fill();
        umi_out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, i);
            @(negedge clk);
            total++; if (umi_in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d got=%0b exp=1", i, umi_in_ready); end
            next_cycle();
            set_in(1'b0, 0);
            @(negedge clk);
            total++; if (fifo_level !== 3'(i)) begin bad++; $display("FAIL fill_level_%0d got=%0d exp=%0d", i, fifo_level, i); end
            total++; if (fifo_afull !== (i >= 3)) begin bad++; $display("FAIL fill_afull_%0d got=%0b exp=%0b", i, fifo_afull, i >= 3); end
            total++; if (fifo_full !== (i == 4)) begin bad++; $display("FAIL fill_full_%0d got=%0b exp=%0b", i, fifo_full, i == 4); end
            next_cycle();
        end
        set_in(1'b1, 99);
        @(negedge clk);
        total++; if (umi_in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%0b exp=0", umi_in_ready); end
        next_cycle();
        set_in(1'b0, 0);
        @(negedge clk);
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL full_no_push_level got=%0d exp=4", fifo_level); end
        next_cycle();
    endtask

    task automatic test_drain();
        umi_out_ready = 1'b1;
        set_in(1'b0, 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            total++; if (umi_out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid_%0d got=%0b exp=1", i, umi_out_valid); end
            total++; if (umi_out_data !== DW'(i)) begin bad++; $display("FAIL drain_data_%0d got=%0h exp=%0h", i, umi_out_data, i); end
            total++; if (umi_out_cmd !== (CW'(i) ^ 32'hC0DE_0000)) begin bad++; $display("FAIL drain_cmd_%0d got=%0h", i, umi_out_cmd); end
            if (i == 1) begin
                total++; if (umi_in_ready !== 1'b0) begin bad++; $display("FAIL drain_full_ready got=%0b exp=0", umi_in_ready); end
            end
            if (i == 2) begin
                total++; if (umi_in_ready !== 1'b1) begin bad++; $display("FAIL drain_ready_reassert got=%0b exp=1", umi_in_ready); end
            end
            next_cycle();
        end
        @(negedge clk);
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0b exp=1", fifo_empty); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL drain_level got=%0d exp=0", fifo_level); end
        total++; if (umi_out_valid !== 1'b0) begin bad++; $display("FAIL drain_out_valid got=%0b exp=0", umi_out_valid); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        umi_out_ready = 1'b1;
        set_in(1'b1, 0);
        @(negedge clk);
        total++; if (umi_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_fallthrough got=%0b exp=0", umi_out_valid); end
        next_cycle();
        for (int k = 1; k < 20; k++) begin
            set_in(1'b1, k);
            @(negedge clk);
            total++; if (umi_out_data !== DW'(k - 1) || umi_out_valid !== 1'b1) begin bad++; $display("FAIL b2b_data_%0d got=%0h exp=%0h", k, umi_out_data, k - 1); end
            total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL b2b_level_%0d got=%0d exp=1", k, fifo_level); end
            next_cycle();
        end
        set_in(1'b0, 0);
        @(negedge clk);
        total++; if (umi_out_data !== DW'(19)) begin bad++; $display("FAIL b2b_last got=%0h exp=13", umi_out_data); end
        next_cycle();
        @(negedge clk);
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%0b exp=1", fifo_empty); end
        next_cycle();
    endtask

    task automatic test_bypass();
        bypass = 1'b1;
        umi_out_ready = 1'b1;
        set_in(1'b1, 'hAB);
        @(negedge clk);
        total++; if (umi_out_valid !== 1'b1) begin bad++; $display("FAIL byp_valid got=%0b exp=1", umi_out_valid); end
        total++; if (umi_out_data !== DW'('hAB)) begin bad++; $display("FAIL byp_data got=%0h exp=ab", umi_out_data); end
        total++; if (umi_in_ready !== 1'b1) begin bad++; $display("FAIL byp_ready1 got=%0b exp=1", umi_in_ready); end
        umi_out_ready = 1'b0;
        #1;
        total++; if (umi_in_ready !== 1'b0) begin bad++; $display("FAIL byp_ready0 got=%0b exp=0", umi_in_ready); end
        umi_out_ready = 1'b1;
        next_cycle();
        set_in(1'b0, 0);
        @(negedge clk);
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL byp_level got=%0d exp=0", fifo_level); end
        next_cycle();
        bypass = 1'b0;
    endtask

    task automatic test_bypass_nonempty();
        umi_out_ready = 1'b0;
        set_in(1'b1, 'h55);
        next_cycle();
        bypass = 1'b1;
        set_in(1'b1, 'h66);
        @(negedge clk);
        total++; if (umi_out_data !== DW'('h55)) begin bad++; $display("FAIL bypne_head got=%0h exp=55", umi_out_data); end
        next_cycle();
        set_in(1'b0, 0);
        umi_out_ready = 1'b1;
        @(negedge clk);
        total++; if (umi_out_data !== DW'('h55) || fifo_level !== 3'd2) begin bad++; $display("FAIL bypne_first got=%0h lvl=%0d exp=55 lvl=2", umi_out_data, fifo_level); end
        next_cycle();
        @(negedge clk);
        total++; if (umi_out_data !== DW'('h66) || umi_out_valid !== 1'b1) begin bad++; $display("FAIL bypne_second got=%0h exp=66", umi_out_data); end
        next_cycle();
        bypass = 1'b0;
        @(negedge clk);
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL bypne_empty got=%0b exp=1", fifo_empty); end
        next_cycle();
    endtask

    task automatic test_chaos();
        logic [DW-1:0] exp_q[$];
        int sent;
        int recv;
        int cyc;
        bit saw_block;
        sent = 0; recv = 0; cyc = 0; saw_block = 1'b0;
        chaosmode = 1'b1;
        while (recv < 1000 && cyc < 20000) begin
            set_in((sent < 1000) && ($urandom_range(3) != 0), sent);
            umi_out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            if (umi_out_valid && umi_out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL chaos_unexpected got=%0h", umi_out_data);
                end else begin
                    if (umi_out_data !== exp_q[0]) begin bad++; $display("FAIL chaos_order_%0d got=%0h exp=%0h", recv, umi_out_data, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
                recv++;
            end
            if (umi_in_valid && umi_in_ready) begin
                exp_q.push_back(DW'(sent));
                sent++;
            end
            if (!umi_in_ready && !fifo_full) saw_block = 1'b1;
            next_cycle();
            cyc++;
        end
        total++; if (recv !== 1000) begin bad++; $display("FAIL chaos_count got=%0d exp=1000", recv); end
        total++; if (saw_block !== 1'b1) begin bad++; $display("FAIL chaos_block got=%0b exp=1", saw_block); end
        chaosmode = 1'b0;
        set_in(1'b0, 0);
        umi_out_ready = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_midstream();
        umi_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 'h31 + i);
            next_cycle();
        end
        set_in(1'b0, 0);
        @(negedge clk);
        total++; if (fifo_level !== 3'd3) begin bad++; $display("FAIL rst_pre_level got=%0d exp=3", fifo_level); end
        #2;
        nreset = 1'b0;
        #1;
        total++; if (fifo_level !== 3'd0 || fifo_empty !== 1'b1) begin bad++; $display("FAIL rst_async_level got=%0d empty=%0b exp=0/1", fifo_level, fifo_empty); end
        total++; if (umi_out_valid !== 1'b0 || fifo_afull !== 1'b0 || fifo_full !== 1'b0) begin bad++; $display("FAIL rst_async_flags got=%0b%0b%0b exp=000", umi_out_valid, fifo_afull, fifo_full); end
        set_in(1'b1, 'hEE);
        next_cycle();
        #2;
        nreset = 1'b1;
        set_in(1'b0, 0);
        @(negedge clk);
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL rst_discard got=%0b exp=1", fifo_empty); end
        next_cycle();
        set_in(1'b1, 'h77);
        next_cycle();
        set_in(1'b0, 0);
        umi_out_ready = 1'b1;
        @(negedge clk);
        total++; if (umi_out_valid !== 1'b1 || umi_out_data !== DW'('h77)) begin bad++; $display("FAIL rst_first_out got=%0h v=%0b exp=77", umi_out_data, umi_out_valid); end
        next_cycle();
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_bypass();
        test_bypass_nonempty();
        test_chaos();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/umi_fifo_sync.md
UMI_FIFO_SYNC -- requirements
Module: umi_fifo_sync

Interface
REQ-001 SHALL have parameter DW, default 128, UMI data width in bits.
REQ-002 SHALL have parameter AW, default 64, address width in bits.
REQ-003 SHALL have parameter CW, default 32, command width in bits.
REQ-004 SHALL have parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-005 SHALL have parameter AFULL_LVL, default DEPTH-1, level at or above which fifo_afull asserts; range 1..DEPTH.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port nreset, input, 1 bit: reset, asynchronous, active-low.
REQ-008 Port bypass, input, 1 bit: request combinational pass-through.
REQ-009 Port chaosmode, input, 1 bit: enable pseudo-random input back-pressure.
REQ-010 Port umi_in_valid, input, 1 bit, and umi_in_ready, output, 1 bit: input handshake.
REQ-011 Ports umi_in_cmd, input, CW; umi_in_dstaddr, input, AW; umi_in_srcaddr, input, AW; umi_in_data, input, DW: input payload.
REQ-012 Port umi_out_valid, output, 1 bit, and umi_out_ready, input, 1 bit: output handshake.
REQ-013 Ports umi_out_cmd, output, CW; umi_out_dstaddr, output, AW; umi_out_srcaddr, output, AW; umi_out_data, output, DW: output payload.
REQ-014 Ports fifo_full, fifo_empty and fifo_afull, outputs, 1 bit each: status flags.
REQ-015 Port fifo_level, output, $clog2(DEPTH)+1 bits: count of stored entries.

Function
REQ-016 SHALL push when umi_in_valid and umi_in_ready are both 1, and pop when umi_out_valid and umi_out_ready are both 1.
REQ-017 SHALL register pushes; a push into an empty FIFO is visible at the output one cycle later, with no same-cycle fall-through.
REQ-018 umi_out_valid SHALL equal !fifo_empty; the output payload SHALL be the head entry, stable while valid is high and ready is low.
REQ-019 umi_in_ready SHALL equal !fifo_full && !chaos_block, where chaos_block = chaosmode && lfsr[0].
REQ-020 When full with umi_out_ready=1: the pop SHALL occur, no push SHALL occur, and ready SHALL reassert the next cycle.
REQ-021 Simultaneous push and pop when not full and not empty: fifo_level SHALL be unchanged and both pointers SHALL advance.
REQ-022 Read and write pointers SHALL be $clog2(DEPTH)+1 bits; full = MSBs differ and the other bits are equal; empty = pointers equal; wrap SHALL be natural modulo 2*DEPTH.
REQ-023 fifo_level SHALL be the write pointer minus the read pointer, modulo 2*DEPTH, with range 0..DEPTH; fifo_afull SHALL be fifo_level >= AFULL_LVL.
REQ-024 bypass_active SHALL be bypass && fifo_empty.
REQ-025 While bypass_active: umi_out_* SHALL equal umi_in_* combinationally; umi_in_ready SHALL equal umi_out_ready; no push SHALL occur; chaos SHALL be ignored.
REQ-026 Asserting bypass while the FIFO is non-empty SHALL have no effect until the FIFO drains, so ordering is preserved.
REQ-027 The LFSR SHALL be 16 bits, polynomial x^16+x^14+x^13+x^11+1, advancing every cycle regardless of chaosmode.
REQ-028 Chaos SHALL gate only umi_in_ready, never umi_out_valid.
REQ-029 Entries written during the cycle reset asserts SHALL be discarded.

Reset
REQ-030 On nreset=0, asynchronously: pointers 0; fifo_level 0; fifo_empty 1; fifo_full 0; fifo_afull 0; umi_out_valid 0; LFSR 16'h0001.
REQ-031 Storage array SHALL NOT be reset; output payload is don't-care while umi_out_valid=0.
REQ-032 Deassertion SHALL be synchronised by the integrating design; the block SHALL assume deassertion away from the clk edge.

Structure
REQ-033 No new package is needed; UMI field widths come from parameters.
REQ-034 The LFSR SHALL be a separate sub-module, umi_fifo_lfsr, with ports clk, nreset and lfsr[15:0].
REQ-035 Storage SHALL be a flat register array of {cmd, dstaddr, srcaddr, data}, CW+2*AW+DW bits wide.

Verification
REQ-036 Scenario (DEPTH=4, out_ready=0): push 4 entries with data 1..4 -> fifo_full=1, fifo_level=4, in_ready=0, afull=1 from level 3.
REQ-037 Scenario (full, out_ready=1 for 4 cycles, in_valid=0): outputs 1, 2, 3, 4 in order, one per cycle -> then empty=1, level=0, out_valid=0.
REQ-038 Scenario (continuous push and pop for 20 entries, data k): output sequence k=0..19 with no loss; pointers wrap at least twice; level stays constant.
REQ-039 Scenario (bypass=1, empty): in_valid=1, data=0xAB in cycle n -> out_valid=1 and out_data=0xAB in cycle n; level stays 0.
REQ-040 Scenario (chaosmode=1, 1000 random transfers, with the scoreboard taken from the umi_tx_sim/umi_rx_sim agents): every packet arrives in order; in_ready is low in some cycles even when the FIFO is not full.
REQ-041 Scenario (nreset pulsed low mid-stream with level=3): outputs reach their reset values immediately; after release, the first new push is the first entry out.
